// File: rtl/mm_arb2_pkg.sv
// Shared types and helpers for the two-master register-bus arbiter.
// The FSM encoding, default bus widths and the round-robin pick live here.
package mm_arb2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  localparam int MM_ADDR_WIDTH_DEF = 8;
  localparam int MM_DATA_WIDTH_DEF = 16;

  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

  // A contest goes to whichever master did not win last time; a lone request wins outright.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
    if (req0 && req1) return ~last_grant;
    return req1;
  endfunction

endpackage

// File: rtl/mm_rr_arb2.sv
// Combinational round-robin winner select between two requesters.
module mm_rr_arb2
  import mm_arb2_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = rr_pick(req0, req1, last_grant);
  end

endmodule

// File: rtl/mm_arb2.sv
// Two-master round-robin arbiter in front of mm_con's single master port.
// One transaction at a time: IDLE -> ADDR -> DATA -> DONE, all outputs registered.
module mm_arb2
  import mm_arb2_pkg::*;
#(
  parameter int MM_ADDR_WIDTH = MM_ADDR_WIDTH_DEF,
  parameter int MM_DATA_WIDTH = MM_DATA_WIDTH_DEF
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_n_i,
  input  logic                     m0_req_i,
  input  logic [MM_ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [MM_DATA_WIDTH-1:0] m0_wdata_i,
  input  logic                     m0_we_i,
  output logic [MM_DATA_WIDTH-1:0] m0_rdata_o,
  output logic                     m0_ack_o,
  input  logic                     m1_req_i,
  input  logic [MM_ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [MM_DATA_WIDTH-1:0] m1_wdata_i,
  input  logic                     m1_we_i,
  output logic [MM_DATA_WIDTH-1:0] m1_rdata_o,
  output logic                     m1_ack_o,
  output logic [MM_ADDR_WIDTH-1:0] bus_addr_o,
  output logic [MM_DATA_WIDTH-1:0] bus_wdata_o,
  output logic                     bus_we_o,
  input  logic [MM_DATA_WIDTH-1:0] bus_rdata_i,
  output logic                     grant_o,
  output logic                     busy_o
);

  arb_state_t state;
  logic       last_grant;
  logic       arb_valid;
  logic       arb_winner;

  mm_rr_arb2 u_rr (
    .req0       (m0_req_i),
    .req1       (m1_req_i),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      last_grant  <= GRANT_M1;
      grant_o     <= 1'b0;
      busy_o      <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_we_o    <= 1'b0;
      m0_rdata_o  <= '0;
      m0_ack_o    <= 1'b0;
      m1_rdata_o  <= '0;
      m1_ack_o    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Requests are only looked at here; the bus regs hold the latched copy afterwards.
          if (arb_valid) begin
            state      <= ST_ADDR;
            busy_o     <= 1'b1;
            grant_o    <= arb_winner;
            last_grant <= arb_winner;
            if (arb_winner == GRANT_M1) begin
              bus_addr_o  <= m1_addr_i;
              bus_wdata_o <= m1_wdata_i;
              bus_we_o    <= m1_we_i;
            end else begin
              bus_addr_o  <= m0_addr_i;
              bus_wdata_o <= m0_wdata_i;
              bus_we_o    <= m0_we_i;
            end
          end
        end
        ST_ADDR: begin
          state    <= ST_DATA;
          bus_we_o <= 1'b0;
        end
        ST_DATA: begin
          // mm_con registered the read at the end of ADDR, so bus_rdata_i is valid now.
          state <= ST_DONE;
          if (grant_o == GRANT_M1) begin
            m1_rdata_o <= bus_rdata_i;
            m1_ack_o   <= 1'b1;
          end else begin
            m0_rdata_o <= bus_rdata_i;
            m0_ack_o   <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          busy_o   <= 1'b0;
          m0_ack_o <= 1'b0;
          m1_ack_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_arb2.sv
// Directed bench for mm_arb2 with a registered-read mm_con register file model.
module tb_mm_arb2;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk_sys_i = 1'b0;
  logic          rst_n_i;
  logic          m0_req_i, m0_we_i, m0_ack_o;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_wdata_i, m0_rdata_o;
  logic          m1_req_i, m1_we_i, m1_ack_o;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_wdata_i, m1_rdata_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o, bus_rdata_i;
  logic          bus_we_o, grant_o, busy_o;

  logic [DW-1:0] mem [256];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  int checks   = 0;
  int failures = 0;

  localparam int ALLZ_W = 5 + AW + 3 * DW;

  mm_arb2 #(.MM_ADDR_WIDTH(AW), .MM_DATA_WIDTH(DW)) dut (
    .clk_sys_i   (clk_sys_i),
    .rst_n_i     (rst_n_i),
    .m0_req_i    (m0_req_i),
    .m0_addr_i   (m0_addr_i),
    .m0_wdata_i  (m0_wdata_i),
    .m0_we_i     (m0_we_i),
    .m0_rdata_o  (m0_rdata_o),
    .m0_ack_o    (m0_ack_o),
    .m1_req_i    (m1_req_i),
    .m1_addr_i   (m1_addr_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_we_i     (m1_we_i),
    .m1_rdata_o  (m1_rdata_o),
    .m1_ack_o    (m1_ack_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_we_o    (bus_we_o),
    .bus_rdata_i (bus_rdata_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  // mm_con model: write on the ADDR edge, read data registered one cycle later.
  always @(posedge clk_sys_i) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus_we_o) mem[bus_addr_o] <= bus_wdata_o;
    bus_rdata_i <= mem[bus_addr_o];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [ALLZ_W-1:0] all_outs();
    return {busy_o, grant_o, bus_we_o, m0_ack_o, m1_ack_o, bus_addr_o, bus_wdata_o, m0_rdata_o, m1_rdata_o};
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk_sys_i);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clk_sys_i);
    ld_en   = 1'b0;
  endtask

  task automatic wait_ack(input bit m, output int n);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_sys_i);
      @(negedge clk_sys_i);
      n++;
      if (m ? m1_ack_o : m0_ack_o) break;
    end
  endtask

  task automatic test_reset();
    int n;
    int ack_seen;
    @(negedge clk_sys_i);
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_outs: got %0h expected 0", all_outs());
    end
    rst_n_i = 1'b1;
    // m1 read, then reset in DATA
    @(negedge clk_sys_i);
    m1_addr_i = 8'h33; m1_we_i = 1'b0; m1_req_i = 1'b1;
    @(posedge clk_sys_i); @(negedge clk_sys_i);
    checks++;
    if (grant_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_lone_m1_grant: got %0b expected 1", grant_o);
    end
    @(posedge clk_sys_i); @(negedge clk_sys_i);
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_midrun_outs: got %0h expected 0", all_outs());
    end
    m1_req_i = 1'b0;
    ack_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_sys_i);
      if (m0_ack_o || m1_ack_o || busy_o) ack_seen++;
    end
    checks++;
    if (ack_seen !== 0) begin
      failures++;
      $display("FAIL reset_hold_quiet: got %0d active cycles expected 0", ack_seen);
    end
    rst_n_i = 1'b1;
    @(negedge clk_sys_i);
    m0_addr_i = 8'h01; m0_we_i = 1'b0; m0_req_i = 1'b1;
    m1_addr_i = 8'h02; m1_we_i = 1'b0; m1_req_i = 1'b1;
    @(posedge clk_sys_i); @(negedge clk_sys_i);
    checks++;
    if (grant_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_contest: got grant=%0b busy=%0b expected grant=0 busy=1", grant_o, busy_o);
    end
    wait_ack(1'b0, n);
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL reset_first_ack: got %0d cycles expected 2", n);
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    @(negedge clk_sys_i);
  endtask

  task automatic test_write_m0();
    int we_cnt, we_cyc, ack_cyc, m1_acks;
    logic [AW-1:0] we_addr;
    we_cnt = 0; we_cyc = 0; ack_cyc = 0; m1_acks = 0; we_addr = '0;
    @(negedge clk_sys_i);
    m0_addr_i = 8'h0E; m0_wdata_i = 16'h00A5; m0_we_i = 1'b1; m0_req_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk_sys_i); @(negedge clk_sys_i);
      if (bus_we_o) begin
        we_cnt++; we_cyc = c; we_addr = bus_addr_o;
      end
      if (m1_ack_o) m1_acks++;
      if (m0_ack_o && ack_cyc == 0) begin
        ack_cyc  = c;
        m0_req_i = 1'b0;
      end
    end
    checks++;
    if (we_cnt !== 1 || we_cyc !== 1) begin
      failures++;
      $display("FAIL write_we_pulse: got count=%0d cycle=%0d expected count=1 cycle=1", we_cnt, we_cyc);
    end
    checks++;
    if (we_addr !== 8'h0E) begin
      failures++;
      $display("FAIL write_addr: got %0h expected 0e", we_addr);
    end
    checks++;
    if (ack_cyc !== 3 || m1_acks !== 0) begin
      failures++;
      $display("FAIL write_ack: got m0 cycle=%0d m1 acks=%0d expected cycle=3 m1 acks=0", ack_cyc, m1_acks);
    end
    checks++;
    if (mem[8'h0E] !== 16'h00A5) begin
      failures++;
      $display("FAIL write_landed: got %0h expected 00a5", mem[8'h0E]);
    end
    checks++;
    if (bus_addr_o !== 8'h0E || bus_wdata_o !== 16'h00A5 || bus_we_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL write_idle_hold: got addr=%0h wdata=%0h we=%0b busy=%0b expected 0e 00a5 0 0",
               bus_addr_o, bus_wdata_o, bus_we_o, busy_o);
    end
  endtask

  task automatic test_read_m1();
    int m0_acks, we_hi;
    logic ack_ok;
    m0_acks = 0; we_hi = 0; ack_ok = 1'b0;
    preload(8'h00, 16'h5A01);
    @(negedge clk_sys_i);
    m1_addr_i = 8'h00; m1_we_i = 1'b0; m1_wdata_i = 16'hFFFF; m1_req_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk_sys_i); @(negedge clk_sys_i);
      if (c == 1) begin
        checks++;
        if (grant_o !== 1'b1) begin
          failures++;
          $display("FAIL read_grant: got %0b expected 1", grant_o);
        end
      end
      if (c == 3) begin
        ack_ok = m1_ack_o;
        checks++;
        if (m1_rdata_o !== 16'h5A01) begin
          failures++;
          $display("FAIL read_data: got %0h expected 5a01", m1_rdata_o);
        end
        m1_req_i = 1'b0;
      end
      if (m0_ack_o) m0_acks++;
      if (bus_we_o) we_hi++;
    end
    checks++;
    if (ack_ok !== 1'b1 || m0_acks !== 0 || we_hi !== 0) begin
      failures++;
      $display("FAIL read_ack: got m1 ack=%0b m0 acks=%0d we cycles=%0d expected 1 0 0", ack_ok, m0_acks, we_hi);
    end
  endtask

  task automatic test_back_to_back();
    int acks, order_err, gap_err, dual, last_c;
    bit expect_m;
    acks = 0; order_err = 0; gap_err = 0; dual = 0; last_c = -1; expect_m = 1'b0;
    @(negedge clk_sys_i);
    m0_addr_i = 8'h10; m0_we_i = 1'b0; m0_req_i = 1'b1;
    m1_addr_i = 8'h20; m1_we_i = 1'b0; m1_req_i = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk_sys_i); @(negedge clk_sys_i);
      if (m0_ack_o && m1_ack_o) dual++;
      if (m0_ack_o || m1_ack_o) begin
        if (m1_ack_o !== expect_m) order_err++;
        if (last_c >= 0 && c - last_c != 4) gap_err++;
        if (last_c < 0 && c != 3) gap_err++;
        expect_m = ~expect_m;
        last_c = c;
        acks++;
      end
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    checks++;
    if (acks !== 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected 8", acks);
    end
    checks++;
    if (order_err !== 0 || dual !== 0) begin
      failures++;
      $display("FAIL b2b_order: got %0d out-of-order %0d dual acks expected 0 0", order_err, dual);
    end
    checks++;
    if (gap_err !== 0) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d bad gaps expected 0", gap_err);
    end
    @(negedge clk_sys_i);
  endtask

  task automatic test_latch_and_drop();
    int we_hi;
    logic ack_ok;
    we_hi = 0; ack_ok = 1'b0;
    preload(8'h04, 16'h1234);
    @(negedge clk_sys_i);
    m0_addr_i = 8'h04; m0_we_i = 1'b0; m0_wdata_i = 16'h0000; m0_req_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk_sys_i); @(negedge clk_sys_i);
      if (bus_we_o) we_hi++;
      if (c == 1) begin
        m0_addr_i = 8'h08; m0_we_i = 1'b1; m0_wdata_i = 16'hDEAD;
      end
      if (c == 2) begin
        checks++;
        if (bus_addr_o !== 8'h04) begin
          failures++;
          $display("FAIL latch_addr: got %0h expected 04", bus_addr_o);
        end
        m0_req_i = 1'b0;
      end
      if (c == 3) begin
        ack_ok = m0_ack_o;
        checks++;
        if (m0_rdata_o !== 16'h1234) begin
          failures++;
          $display("FAIL latch_rdata: got %0h expected 1234", m0_rdata_o);
        end
      end
      if (c == 5) begin
        checks++;
        if (busy_o !== 1'b0 || m0_ack_o !== 1'b0) begin
          failures++;
          $display("FAIL drop_no_regrant: got busy=%0b ack=%0b expected 0 0", busy_o, m0_ack_o);
        end
      end
    end
    checks++;
    if (ack_ok !== 1'b1 || we_hi !== 0 || mem[8'h08] === 16'hDEAD) begin
      failures++;
      $display("FAIL drop_ack: got ack=%0b we cycles=%0d expected ack=1 we cycles=0 and no write", ack_ok, we_hi);
    end
  endtask

  task automatic test_reset_in_addr();
    int n, acks;
    acks = 0;
    @(negedge clk_sys_i);
    m1_addr_i = 8'h30; m1_wdata_i = 16'hBEEF; m1_we_i = 1'b1; m1_req_i = 1'b1;
    @(posedge clk_sys_i); @(negedge clk_sys_i);
    checks++;
    if (bus_we_o !== 1'b1 || grant_o !== 1'b1) begin
      failures++;
      $display("FAIL addr_we_high: got we=%0b grant=%0b expected 1 1", bus_we_o, grant_o);
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL addr_reset_outs: got %0h expected 0", all_outs());
    end
    m1_req_i = 1'b0;
    @(negedge clk_sys_i);
    rst_n_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_sys_i); @(negedge clk_sys_i);
      if (m0_ack_o || m1_ack_o || busy_o) acks++;
    end
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL addr_reset_no_ack: got %0d active cycles expected 0", acks);
    end
    m0_addr_i = 8'h05; m0_we_i = 1'b0; m0_req_i = 1'b1;
    m1_addr_i = 8'h06; m1_we_i = 1'b0; m1_req_i = 1'b1;
    @(posedge clk_sys_i); @(negedge clk_sys_i);
    checks++;
    if (grant_o !== 1'b0) begin
      failures++;
      $display("FAIL addr_reset_next_grant: got %0b expected 0", grant_o);
    end
    wait_ack(1'b0, n);
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL addr_reset_next_ack: got %0d cycles expected 2", n);
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    @(negedge clk_sys_i);
  endtask

  initial begin
    rst_n_i    = 1'b0;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    m0_req_i   = 1'b0; m0_addr_i = '0; m0_wdata_i = '0; m0_we_i = 1'b0;
    m1_req_i   = 1'b0; m1_addr_i = '0; m1_wdata_i = '0; m1_we_i = 1'b0;
    repeat (2) @(negedge clk_sys_i);
    test_reset();
    test_write_m0();
    test_read_m1();
    test_back_to_back();
    test_latch_and_drop();
    test_reset_in_addr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
